// File: rtl/tt_sweep_if.sv
// Bus between the truth-table sweep harness and its controller / circuit under test.
// Optional TT_MISMATCH_LOG_EN adds the per-vector mismatch log signals.
interface tt_sweep_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2
);
    localparam int TW = N_OUT * (1 << N_IN);

    logic              start;
    logic [N_IN-1:0]   x;
    logic [N_OUT-1:0]  f;
    logic [TW-1:0]     exp_tt;
    logic              busy;
    logic              done;
    logic [TW-1:0]     tt;
    logic              match;
`ifdef TT_MISMATCH_LOG_EN
    logic [N_IN-1:0]   mm_idx;
    logic [N_IN:0]     mm_cnt;

    modport master (
        output start, f, exp_tt,
        input  x, busy, done, tt, match, mm_idx, mm_cnt
    );
    modport slave (
        input  start, f, exp_tt,
        output x, busy, done, tt, match, mm_idx, mm_cnt
    );
`else
    modport master (
        output start, f, exp_tt,
        input  x, busy, done, tt, match
    );
    modport slave (
        input  start, f, exp_tt,
        output x, busy, done, tt, match
    );
`endif
endinterface

// File: rtl/tt_sweep_capture.sv
// Sweeps all 2^N_IN input vectors through a combinational circuit, captures its truth table
// and flags whether it equals the expected table. TT_MISMATCH_LOG_EN adds a per-vector mismatch log.
module tt_sweep_capture #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input logic      clk,
    input logic      rst_n,
    tt_sweep_if.slave bus
);
    localparam int            NV          = 1 << N_IN;
    localparam int            TW          = N_OUT * NV;
    localparam logic [N_IN:0] LAST_VEC    = (N_IN + 1)'(NV - 1);
    localparam logic [7:0]    SETTLE_INIT = 8'(SETTLE);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN:0]   vec_q, vec_d;
    logic [7:0]      settle_q, settle_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            match_q, match_d;
    logic [TW-1:0]   tt_sample;
    logic [N_IN-1:0] vec_idx;
`ifdef TT_MISMATCH_LOG_EN
    logic [N_IN-1:0] mm_idx_q, mm_idx_d;
    logic [N_IN:0]   mm_cnt_q, mm_cnt_d;
    logic            mm_hit;
`endif

    assign vec_idx = vec_q[N_IN-1:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        tt_d      = tt_q;
        exp_d     = exp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        tt_sample = tt_q;
        for (int o = 0; o < N_OUT; o++) begin
            tt_sample[o*NV + int'(vec_idx)] = bus.f[o];
        end
`ifdef TT_MISMATCH_LOG_EN
        mm_idx_d = mm_idx_q;
        mm_cnt_d = mm_cnt_q;
        mm_hit   = 1'b0;
        for (int o = 0; o < N_OUT; o++) begin
            mm_hit = mm_hit | (bus.f[o] ^ exp_q[o*NV + int'(vec_idx)]);
        end
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = HOLD;
                    vec_d    = '0;
                    settle_d = SETTLE_INIT;
                    tt_d     = '0;
                    exp_d    = bus.exp_tt;
                    busy_d   = 1'b1;
                    match_d  = 1'b0;
`ifdef TT_MISMATCH_LOG_EN
                    mm_idx_d = '0;
                    mm_cnt_d = '0;
`endif
                end
            end
            HOLD: begin
                if (settle_q != 8'd0) begin
                    settle_d = settle_q - 8'd1;
                end else begin
                    tt_d = tt_sample;
`ifdef TT_MISMATCH_LOG_EN
                    if (mm_hit) begin
                        if (mm_cnt_q == '0) mm_idx_d = vec_idx;
                        mm_cnt_d = mm_cnt_q + 1'b1;
                    end
`endif
                    // Match must include the sample taken on this very edge.
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        match_d = (tt_sample == exp_q);
                    end else begin
                        vec_d    = vec_q + 1'b1;
                        settle_d = SETTLE_INIT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            tt_q     <= '0;
            exp_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
`ifdef TT_MISMATCH_LOG_EN
            mm_idx_q <= '0;
            mm_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            tt_q     <= tt_d;
            exp_q    <= exp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
`ifdef TT_MISMATCH_LOG_EN
            mm_idx_q <= mm_idx_d;
            mm_cnt_q <= mm_cnt_d;
`endif
        end
    end

    assign bus.x     = vec_idx;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tt    = tt_q;
    assign bus.match = match_q;
`ifdef TT_MISMATCH_LOG_EN
    assign bus.mm_idx = mm_idx_q;
    assign bus.mm_cnt = mm_cnt_q;
`endif
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: circuit f0=x0&x1, f1=~x3 on a SETTLE=1 and a SETTLE=0 instance,
// expected results queued at start and compared at done.
module tb_tt_sweep_capture;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int NV    = 16;

    typedef struct {
        logic [31:0] tt;
        logic        match;
        int          mm_cnt;
        int          mm_idx;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic sel = 1'b1;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_sweep_if #(.N_IN(N_IN), .N_OUT(N_OUT)) b1 ();
    tt_sweep_if #(.N_IN(N_IN), .N_OUT(N_OUT)) b0 ();

    assign b1.f = {~b1.x[3], b1.x[0] & b1.x[1]};
    assign b0.f = {~b0.x[3], b0.x[0] & b0.x[1]};

    tt_sweep_capture #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    tt_sweep_capture #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));

    wire        done_m  = sel ? b1.done  : b0.done;
    wire        busy_m  = sel ? b1.busy  : b0.busy;
    wire [3:0]  x_m     = sel ? b1.x     : b0.x;
    wire [31:0] tt_m    = sel ? b1.tt    : b0.tt;
    wire        match_m = sel ? b1.match : b0.match;
`ifdef TT_MISMATCH_LOG_EN
    wire [3:0]  mm_idx_m = sel ? b1.mm_idx : b0.mm_idx;
    wire [4:0]  mm_cnt_m = sel ? b1.mm_cnt : b0.mm_cnt;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) b1.start = v; else b0.start = v;
    endtask

    task automatic drive_exp(input logic [31:0] v);
        if (sel) b1.exp_tt = v; else b0.exp_tt = v;
    endtask

    function automatic logic [31:0] golden();
        logic [31:0] g;
        logic [3:0]  v;
        g = '0;
        for (int i = 0; i < NV; i++) begin
            v         = 4'(i);
            g[i]      = v[0] & v[1];
            g[NV + i] = ~v[3];
        end
        return g;
    endfunction

    function automatic exp_t model(input logic [31:0] e, input int settle);
        exp_t        r;
        logic [31:0] g;
        g        = golden();
        r.tt     = g;
        r.match  = (g == e);
        r.mm_cnt = 0;
        r.mm_idx = 0;
        r.lat    = NV * (settle + 1);
        for (int i = 0; i < NV; i++) begin
            if ((g[i] != e[i]) || (g[NV + i] != e[NV + i])) begin
                if (r.mm_cnt == 0) r.mm_idx = i;
                r.mm_cnt++;
            end
        end
        return r;
    endfunction

    // pulse_a/pulse_b: sweep cycle whose edge sees a stray start; mid_at: cycle exp_tt is changed.
    task automatic run_sweep(input logic [31:0] e, input int settle, input int pulse_a,
                             input int pulse_b, input int mid_at, input logic [31:0] e_mid);
        exp_t exp_r;
        int   t0;
        int   k;
        int   xe;
        logic got_done;
        sb.push_back(model(e, settle));
        @(negedge clk);
        drive_exp(e);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        t0       = cyc;
        k        = 0;
        got_done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            k = cyc - t0;
            if (done_m) begin
                got_done = 1'b1;
                break;
            end
            xe = k / (settle + 1);
            if (xe > NV - 1) xe = NV - 1;
            check("busy_in_sweep", 64'(busy_m), 64'(1));
            check("x_in_sweep", 64'(x_m), 64'(xe));
            drive_start((k == pulse_a - 1) || (k == pulse_b - 1));
            if (k == mid_at) drive_exp(e_mid);
            @(negedge clk);
        end
        drive_start(1'b0);
        check("done_seen", 64'(got_done), 64'(1));
        exp_r = sb.pop_front();
        check("latency", 64'(k), 64'(exp_r.lat));
        check("tt", 64'(tt_m), 64'(exp_r.tt));
        check("match", 64'(match_m), 64'(exp_r.match));
        check("busy_at_done", 64'(busy_m), 64'(0));
        check("x_at_done", 64'(x_m), 64'(NV - 1));
`ifdef TT_MISMATCH_LOG_EN
        check("mm_cnt", 64'(mm_cnt_m), 64'(exp_r.mm_cnt));
        check("mm_idx", 64'(mm_idx_m), 64'(exp_r.mm_idx));
`endif
        // Start during DONE must be ignored; done must be a single pulse.
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        check("done_pulse", 64'(done_m), 64'(0));
        check("busy_after", 64'(busy_m), 64'(0));
        check("tt_held", 64'(tt_m), 64'(exp_r.tt));
        check("match_held", 64'(match_m), 64'(exp_r.match));
        check("x_held", 64'(x_m), 64'(NV - 1));
    endtask

    initial begin
        logic [31:0] g;
        g         = golden();
        b1.start  = 1'b0;
        b0.start  = 1'b0;
        b1.exp_tt = '0;
        b0.exp_tt = '0;

        #1;
        check("rst_x", 64'(b1.x), 64'(0));
        check("rst_busy", 64'(b1.busy), 64'(0));
        check("rst_done", 64'(b1.done), 64'(0));
        check("rst_tt", 64'(b1.tt), 64'(0));
        check("rst_match", 64'(b1.match), 64'(0));
        check("rst0_tt", 64'(b0.tt), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b1;
        run_sweep(32'h00FF_8888, 1, -10, -10, -10, '0);
        run_sweep(32'h00FF_8889, 1, -10, -10, -10, '0);
        run_sweep(g, 1, 5, 31, -10, '0);
        run_sweep(g, 1, -10, -10, 10, 32'h1234_5678);
        run_sweep(32'hFFFF_FFFF, 1, -10, -10, 10, g);
        run_sweep(g ^ 32'h0200_0020, 1, -10, -10, -10, '0);

        sel = 1'b0;
        run_sweep(g, 0, -10, -10, -10, '0);
        run_sweep(32'h00FF_0888, 0, 3, 15, -10, '0);

        // Reset ten cycles into a sweep, then a fresh full sweep.
        sel = 1'b1;
        @(negedge clk);
        drive_exp(g);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        repeat (9) @(negedge clk);
        check("mid_busy", 64'(b1.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_x", 64'(b1.x), 64'(0));
        check("mid_rst_busy", 64'(b1.busy), 64'(0));
        check("mid_rst_tt", 64'(b1.tt), 64'(0));
        check("mid_rst_match", 64'(b1.match), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(g, 1, -10, -10, -10, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
